// File: rtl/mips_multicycle_fsm.sv
// ---------------------------------------------------------------------------
// mips_multicycle_fsm
//
// Main control state machine for the multicycle MIPS core. It sequences the
// shared ALU, memory, IR, PC and register file over several cycles for each
// instruction. It is a Moore machine: every output is decoded from the
// current state. PCEn also depends on Zero, and Illegal also depends on
// Opcode while the machine is in DECODE.
//
// Optional feature macro: MIPS_FSM_BNE_EN
//   defined   -> bne (000101) is supported. An isBne flag is latched in
//                DECODE, and BRANCH takes the branch when Zero ^ isBne.
//   undefined -> 000101 is treated as an illegal opcode.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous reset, active-low
//   Opcode[5:0] in  IR[31:26], held by the IR from DECODE until FETCH
//   Zero       in   ALU zero flag
//   IorD       out  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite   out  data memory write enable
//   IRWrite    out  instruction register load
//   RegDst     out  write register select (0 = rt, 1 = rd)
//   MemtoReg   out  write-back source (0 = ALUOut, 1 = Data)
//   RegWrite   out  register file write enable
//   ALUSrcA    out  ALU A source (0 = PC, 1 = A)
//   ALUSrcB[1:0] out ALU B source (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2)
//   ALUOp[1:0] out  to ALU decoder (00 add, 01 sub, 10 funct, 11 opcode)
//   PCSrc[1:0] out  next-PC source (00 ALUResult, 01 ALUOut, 10 jump target)
//   PCEn       out  PC load enable
//   InstrDone  out  one-cycle pulse in the final state of each instruction
//   Illegal    out  one-cycle pulse in DECODE for an unsupported opcode
//   State[3:0] out  current state, for debug
// ---------------------------------------------------------------------------
module mips_multicycle_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       InstrDone,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_FSM_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t state_q, state_d;

  // run_q is cleared by reset and set on the first clock edge after release.
  // While it is clear, the machine holds FETCH and suppresses all write
  // enables. As a result, the partial cycle in which reset is released
  // never writes, and the first real FETCH begins on the next edge.
  logic run_q, run_d;

  // Raw (ungated) decoded controls.
  logic mem_write_raw, ir_write_raw, reg_write_raw;
  logic pc_write, branch, done_raw, illegal_raw;
  logic branch_cond;

`ifdef MIPS_FSM_BNE_EN
  logic isbne_q, isbne_d;
`endif

  // -------------------------------------------------------------------------
  // Next state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSrc         = 2'b00;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    done_raw      = 1'b0;
    illegal_raw   = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB      = 2'b01;
        ir_write_raw = 1'b1;
        pc_write     = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:                        state_d = S_MEMADR;
          OP_RTYPE:                            state_d = S_EXEC;
          OP_BEQ:                              state_d = S_BRANCH;
`ifdef MIPS_FSM_BNE_EN
          OP_BNE:                              state_d = S_BRANCH;
`endif
          OP_ADDI, OP_ORI, OP_XORI, OP_SLTI:   state_d = S_IMMEX;
          OP_J:                                state_d = S_JUMP;
          default: begin
            illegal_raw = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // Opcode is read again here to choose between lw and sw. The IR must
        // therefore still hold it.
        state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSrc    = 2'b01;
        branch   = 1'b1;
        done_raw = 1'b1;
        state_d  = S_FETCH;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
        done_raw = 1'b1;
        state_d  = S_FETCH;
      end
      // Unused codes 12-15: all outputs stay at 0, and the machine recovers
      // to FETCH on the next edge.
      default: state_d = S_FETCH;
    endcase

    if (!run_q) begin
      state_d = S_FETCH;
    end
  end

  assign run_d = 1'b1;

`ifdef MIPS_FSM_BNE_EN
  always_comb begin
    isbne_d = isbne_q;
    if (state_q == S_DECODE) begin
      isbne_d = (Opcode == OP_BNE);
    end
  end
  assign branch_cond = Zero ^ isbne_q;
`else
  assign branch_cond = Zero;
`endif

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

`ifdef MIPS_FSM_BNE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      isbne_q <= 1'b0;
    end else begin
      isbne_q <= isbne_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Write enables and pulses are gated combinationally by reset_n, so they
  // drop in the same instant reset asserts. They are also gated by run_q,
  // which keeps them low in the cycle in which reset is released.
  // -------------------------------------------------------------------------
  logic en_ok;
  assign en_ok     = reset_n & run_q;
  assign MemWrite  = mem_write_raw & en_ok;
  assign IRWrite   = ir_write_raw & en_ok;
  assign RegWrite  = reg_write_raw & en_ok;
  assign PCEn      = (pc_write | (branch & branch_cond)) & en_ok;
  assign InstrDone = done_raw & en_ok;
  assign Illegal   = illegal_raw & en_ok;
  assign State     = state_q;

endmodule

// File: tb/tb_mips_multicycle_fsm.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_fsm
//
// Directed testbench for mips_multicycle_fsm. Inputs change on the falling
// edge, and outputs are sampled on the falling edge, away from the rising
// clock edge. Each comparison is an immediate assertion. The bench prints a
// single summary line at the end.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_fsm;

  logic       clk;
  logic       reset_n;
  logic [5:0] Opcode;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, InstrDone, Illegal;
  logic [3:0] State;

  int vec_cnt = 0;
  int err_cnt = 0;

  mips_multicycle_fsm dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Opcode    (Opcode),
    .Zero      (Zero),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .PCSrc     (PCSrc),
    .PCEn      (PCEn),
    .InstrDone (InstrDone),
    .Illegal   (Illegal),
    .State     (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the state that results.
  task automatic step(input string tag, input logic [3:0] exp_state);
    @(negedge clk);
    chk(tag, {4'd0, State}, {4'd0, exp_state});
  endtask

  initial begin
    reset_n = 1'b0;
    Opcode  = 6'b000000;
    Zero    = 1'b0;

    // ---------------- Power-on reset, then start an R-type ---------------
    @(negedge clk);
    @(negedge clk);
    chk("por_state", {4'd0, State}, 8'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_irwrite", {7'd0, IRWrite}, 8'd0);
    chk("rel_pcen",    {7'd0, PCEn},    8'd0);
    step("fetch0", 4'd0);
    chk("fetch0_irwrite", {7'd0, IRWrite}, 8'd1);
    step("rt_decode", 4'd1);
    step("rt_exec", 4'd6);

    // ---------------- Reset asserted mid-EXEC for 3 cycles ---------------
    reset_n = 1'b0;
    #1;
    chk("rst_state",    {4'd0, State},    8'd0);
    chk("rst_pcen",     {7'd0, PCEn},     8'd0);
    chk("rst_irwrite",  {7'd0, IRWrite},  8'd0);
    chk("rst_regwrite", {7'd0, RegWrite}, 8'd0);
    chk("rst_memwrite", {7'd0, MemWrite}, 8'd0);
    chk("rst_alusrcb",  {6'd0, ALUSrcB},  8'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_state", {4'd0, State},   8'd0);
    chk("rst_hold_ir",    {7'd0, IRWrite}, 8'd0);
    reset_n = 1'b1;
    #1;
    chk("rel2_irwrite", {7'd0, IRWrite}, 8'd0);
    chk("rel2_pcen",    {7'd0, PCEn},    8'd0);
    step("fetch1", 4'd0);
    chk("fetch1_irwrite", {7'd0, IRWrite}, 8'd1);
    chk("fetch1_pcen",    {7'd0, PCEn},    8'd1);

    // ---------------- lw: 0,1,2,3,4 ---------------------------------------
    Opcode = 6'b100011;
    step("lw_decode", 4'd1);
    chk("lw_dec_alusrcb", {6'd0, ALUSrcB}, 8'd3);
    chk("lw_dec_done",    {7'd0, InstrDone}, 8'd0);
    step("lw_memadr", 4'd2);
    chk("lw_adr_srca", {7'd0, ALUSrcA}, 8'd1);
    chk("lw_adr_srcb", {6'd0, ALUSrcB}, 8'd2);
    chk("lw_adr_done", {7'd0, InstrDone}, 8'd0);
    step("lw_memrd", 4'd3);
    chk("lw_rd_iord", {7'd0, IorD}, 8'd1);
    chk("lw_rd_done", {7'd0, InstrDone}, 8'd0);
    step("lw_memwb", 4'd4);
    chk("lw_wb_regwrite", {7'd0, RegWrite}, 8'd1);
    chk("lw_wb_memtoreg", {7'd0, MemtoReg}, 8'd1);
    chk("lw_wb_done",     {7'd0, InstrDone}, 8'd1);
    step("lw_fetch", 4'd0);
    chk("lw_fetch_done", {7'd0, InstrDone}, 8'd0);

    // ---------------- sw: 0,1,2,5 -----------------------------------------
    Opcode = 6'b101011;
    step("sw_decode", 4'd1);
    step("sw_memadr", 4'd2);
    chk("sw_adr_memwrite", {7'd0, MemWrite}, 8'd0);
    step("sw_memwr", 4'd5);
    chk("sw_wr_memwrite", {7'd0, MemWrite}, 8'd1);
    chk("sw_wr_iord",     {7'd0, IorD},     8'd1);
    step("sw_fetch", 4'd0);
    chk("sw_fetch_memwrite", {7'd0, MemWrite}, 8'd0);

    // ---------------- R-type: 0,1,6,7 -------------------------------------
    // Opcode is changed during EXEC. The change must not affect the path.
    Opcode = 6'b000000;
    step("rt2_decode", 4'd1);
    step("rt2_exec", 4'd6);
    chk("rt2_exec_aluop", {6'd0, ALUOp}, 8'd2);
    Opcode = 6'b100011;
    step("rt2_aluwb", 4'd7);
    chk("rt2_wb_regdst",   {7'd0, RegDst},   8'd1);
    chk("rt2_wb_regwrite", {7'd0, RegWrite}, 8'd1);
    step("rt2_fetch", 4'd0);

    // ---------------- beq, taken and not taken ----------------------------
    Opcode = 6'b000100;
    Zero   = 1'b1;
    step("beq1_decode", 4'd1);
    step("beq1_branch", 4'd8);
    chk("beq1_pcen",  {7'd0, PCEn},  8'd1);
    chk("beq1_pcsrc", {6'd0, PCSrc}, 8'd1);
    chk("beq1_aluop", {6'd0, ALUOp}, 8'd1);
    step("beq1_fetch", 4'd0);
    Zero = 1'b0;
    step("beq0_decode", 4'd1);
    step("beq0_branch", 4'd8);
    chk("beq0_pcen", {7'd0, PCEn}, 8'd0);
    step("beq0_fetch", 4'd0);

    // ---------------- ori: 0,1,9,10 ---------------------------------------
    Opcode = 6'b001101;
    step("ori_decode", 4'd1);
    step("ori_immex", 4'd9);
    chk("ori_aluop", {6'd0, ALUOp},   8'd3);
    chk("ori_srcb",  {6'd0, ALUSrcB}, 8'd2);
    step("ori_immwb", 4'd10);
    chk("ori_regwrite", {7'd0, RegWrite}, 8'd1);
    chk("ori_regdst",   {7'd0, RegDst},   8'd0);
    step("ori_fetch", 4'd0);

    // ---------------- j: 0,1,11 -------------------------------------------
    Opcode = 6'b000010;
    step("j_decode", 4'd1);
    step("j_jump", 4'd11);
    chk("j_pcsrc", {6'd0, PCSrc}, 8'd2);
    chk("j_pcen",  {7'd0, PCEn},  8'd1);
    chk("j_done",  {7'd0, InstrDone}, 8'd1);
    step("j_fetch", 4'd0);

    // ---------------- Illegal opcode --------------------------------------
    Opcode = 6'b111111;
    step("ill_decode", 4'd1);
    chk("ill_pulse", {7'd0, Illegal}, 8'd1);
    step("ill_fetch", 4'd0);
    chk("ill_clear", {7'd0, Illegal}, 8'd0);

    // ---------------- bne (optional) --------------------------------------
    Opcode = 6'b000101;
    Zero   = 1'b0;
    step("bne_decode", 4'd1);
`ifdef MIPS_FSM_BNE_EN
    chk("bne_no_illegal", {7'd0, Illegal}, 8'd0);
    step("bne0_branch", 4'd8);
    chk("bne0_pcen", {7'd0, PCEn}, 8'd1);
    step("bne0_fetch", 4'd0);
    Zero = 1'b1;
    step("bne1_decode", 4'd1);
    step("bne1_branch", 4'd8);
    chk("bne1_pcen", {7'd0, PCEn}, 8'd0);
    step("bne1_fetch", 4'd0);
`else
    chk("bne_illegal", {7'd0, Illegal}, 8'd1);
    step("bne_fetch", 4'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
